prt_scaler_lbf_ctl: RTL and testbench

Sequencer for the three per-component scaler line buffers (red, green, blue).
- Drives their run, frame-start and test-pattern controls.
- Paces the upstream scaler core with one-line-at-a-time requests, gated by buffer ready.
- Releases the output timing generator once every buffer holds data.
- Detects frame underflow and stalled sources.

---
 rtl/prt_scaler_lbf_ctl.sv | 211 +++++++++++++++++++++
 tb/tb_prt_scaler_lbf_ctl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prt_scaler_lbf_ctl.sv
// Line buffer sequencer: paces scaler line requests, releases the timing generator.
// Optional PRT_SCALER_LBF_CTL_TP_EN: frame-aligned test pattern select.
module prt_scaler_lbf_ctl #(
    parameter int P_LINE_W  = 12,
    parameter int P_TO_W    = 16,
    parameter int P_HOLDOFF = 4
) (
    input  logic                CLK_IN,
    input  logic                RST_IN,
    input  logic                CFG_EN_IN,
    input  logic [P_LINE_W-1:0] CFG_VLINES_IN,
    input  logic                CFG_TP_IN,
    input  logic                TG_VS_IN,
    input  logic [2:0]          LBF_RDY_IN,
    input  logic [2:0]          LBF_RUN_IN,
    output logic                CTL_RUN_OUT,
    output logic                CTL_FS_OUT,
    output logic                CTL_TP_OUT,
    output logic                SRC_LREQ_OUT,
    input  logic                SRC_LACK_IN,
    output logic                TG_RUN_OUT,
    output logic [P_LINE_W-1:0] STA_LINE_OUT,
    output logic                STA_UFL_OUT,
    output logic                STA_ERR_OUT
);

    localparam int P_HO_W = (P_HOLDOFF < 2) ? 1 : $clog2(P_HOLDOFF + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_FS, S_FILL, S_RUN, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic                wait_q, wait_d;
    logic [P_LINE_W-1:0] vlines_q, vlines_d;
    logic [P_LINE_W-1:0] line_q, line_d;
    logic [P_HO_W-1:0]   hold_q, hold_d;
    logic [P_TO_W-1:0]   to_q, to_d;
    logic                req_q, req_d;
    logic                run_q, run_d;
    logic                fs_q, fs_d;
    logic                tp_q, tp_d;
    logic                tg_q, tg_d;
    logic                ufl_q, ufl_d;
    logic                err_q, err_d;
    logic                vs_q, vs_d;

    logic                ack;
    logic                vs_rise;
    logic                go_fs;
    logic                tp_fs;
    logic [P_LINE_W-1:0] line_inc;
    logic [P_LINE_W-1:0] line_ack;
    logic [P_TO_W-1:0]   to_inc;

`ifdef PRT_SCALER_LBF_CTL_TP_EN
    assign tp_fs = CFG_TP_IN;
`else
    logic unused_tp;
    assign unused_tp = CFG_TP_IN;
    assign tp_fs     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        vlines_d = vlines_q;
        line_d   = line_q;
        hold_d   = hold_q;
        to_d     = to_q;
        req_d    = req_q;
        run_d    = run_q;
        fs_d     = 1'b0;
        tp_d     = tp_q;
        tg_d     = tg_q;
        ufl_d    = ufl_q;
        err_d    = err_q;
        vs_d     = TG_VS_IN;
        ack      = req_q & SRC_LACK_IN;
        vs_rise  = TG_VS_IN & ~vs_q;
        go_fs    = 1'b0;
        line_inc = (line_q < vlines_q) ? line_q + 1'b1 : line_q;
        line_ack = ack ? line_inc : line_q;
        to_inc   = to_q + 1'b1;

        if (!CFG_EN_IN) begin
            state_d = S_IDLE;
            run_d   = 1'b0;
            req_d   = 1'b0;
            tg_d    = 1'b0;
            tp_d    = 1'b0;
            line_d  = '0;
            hold_d  = '0;
            to_d    = '0;
            wait_d  = 1'b0;
            if (state_q == S_IDLE) begin
                ufl_d = 1'b0;
                err_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ufl_d   = 1'b0;
                    err_d   = 1'b0;
                    tp_d    = 1'b0;
                    wait_d  = 1'b0;
                    run_d   = 1'b1;
                    state_d = S_START;
                end
                S_START: begin
                    wait_d = 1'b1;
                    go_fs  = wait_q;
                end
                S_FS: begin
                    vlines_d = CFG_VLINES_IN;
                    state_d  = S_FILL;
                end
                S_FILL, S_RUN: begin
                    // one request in flight; holdoff lets buffer levels settle
                    if (ack) begin
                        req_d  = 1'b0;
                        line_d = line_inc;
                        hold_d = P_HO_W'(P_HOLDOFF);
                        to_d   = '0;
                    end else if (req_q) begin
                        to_d = to_inc;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - 1'b1;
                    end else if (&LBF_RDY_IN && line_q < vlines_q) begin
                        req_d = 1'b1;
                        to_d  = '0;
                    end
                    if (state_q == S_FILL) begin
                        if (&LBF_RUN_IN) begin
                            tg_d    = 1'b1;
                            state_d = S_RUN;
                        end
                    end else if (vs_rise) begin
                        go_fs = 1'b1;
                        if (line_ack != vlines_q) ufl_d = 1'b1;
                    end
                    if (req_q && !ack && &to_inc) begin
                        go_fs   = 1'b0;
                        state_d = S_ERR;
                        run_d   = 1'b0;
                        tg_d    = 1'b0;
                        req_d   = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
            if (go_fs) begin
                state_d = S_FS;
                fs_d    = 1'b1;
                line_d  = '0;
                req_d   = 1'b0;
                hold_d  = '0;
                to_d    = '0;
                tp_d    = tp_fs;
            end
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q  <= S_IDLE;
            wait_q   <= 1'b0;
            vlines_q <= '0;
            line_q   <= '0;
            hold_q   <= '0;
            to_q     <= '0;
            req_q    <= 1'b0;
            run_q    <= 1'b0;
            fs_q     <= 1'b0;
            tp_q     <= 1'b0;
            tg_q     <= 1'b0;
            ufl_q    <= 1'b0;
            err_q    <= 1'b0;
            vs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            vlines_q <= vlines_d;
            line_q   <= line_d;
            hold_q   <= hold_d;
            to_q     <= to_d;
            req_q    <= req_d;
            run_q    <= run_d;
            fs_q     <= fs_d;
            tp_q     <= tp_d;
            tg_q     <= tg_d;
            ufl_q    <= ufl_d;
            err_q    <= err_d;
            vs_q     <= vs_d;
        end
    end

    assign CTL_RUN_OUT  = run_q;
    assign CTL_FS_OUT   = fs_q;
    assign CTL_TP_OUT   = tp_q;
    assign SRC_LREQ_OUT = req_q;
    assign TG_RUN_OUT   = tg_q;
    assign STA_LINE_OUT = line_q;
    assign STA_UFL_OUT  = ufl_q;
    assign STA_ERR_OUT  = err_q;

endmodule

// File: tb/tb_prt_scaler_lbf_ctl.sv
// Directed bench for prt_scaler_lbf_ctl (P_TO_W=4, P_HOLDOFF=4).
module tb_prt_scaler_lbf_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [11:0] vlines = 12'd4;
    logic        tp = 1'b0;
    logic        vs = 1'b0;
    logic [2:0]  rdy = 3'b111;
    logic [2:0]  lrun = 3'b000;
    logic        lack = 1'b0;
    logic        run_o, fs_o, tp_o, req_o, tg_o, ufl_o, err_o;
    logic [11:0] line_o;

    int checks = 0;
    int errors = 0;
    logic tp_exp;

    always #5 clk = ~clk;

    prt_scaler_lbf_ctl #(.P_LINE_W(12), .P_TO_W(4), .P_HOLDOFF(4)) dut (
        .CLK_IN(clk), .RST_IN(rst), .CFG_EN_IN(en),
        .CFG_VLINES_IN(vlines), .CFG_TP_IN(tp), .TG_VS_IN(vs),
        .LBF_RDY_IN(rdy), .LBF_RUN_IN(lrun),
        .CTL_RUN_OUT(run_o), .CTL_FS_OUT(fs_o), .CTL_TP_OUT(tp_o),
        .SRC_LREQ_OUT(req_o), .SRC_LACK_IN(lack), .TG_RUN_OUT(tg_o),
        .STA_LINE_OUT(line_o), .STA_UFL_OUT(ufl_o), .STA_ERR_OUT(err_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
`ifdef PRT_SCALER_LBF_CTL_TP_EN
        tp_exp = 1'b1;
`else
        tp_exp = 1'b0;
`endif
        repeat (2) tick();
        chk("rst_run", 32'(run_o), 0);
        chk("rst_fs", 32'(fs_o), 0);
        chk("rst_tp", 32'(tp_o), 0);
        chk("rst_req", 32'(req_o), 0);
        chk("rst_tg", 32'(tg_o), 0);
        chk("rst_line", 32'(line_o), 0);
        chk("rst_ufl", 32'(ufl_o), 0);
        chk("rst_err", 32'(err_o), 0);
        rst = 1'b0;

        // frame of 4 lines
        en = 1'b1;
        tick();
        chk("c1_run", 32'(run_o), 1);
        chk("c1_fs", 32'(fs_o), 0);
        tick();
        chk("c2_fs", 32'(fs_o), 0);
        tick();
        chk("c3_fs", 32'(fs_o), 1);
        chk("c3_line", 32'(line_o), 0);
        rdy = 3'b011;
        tick();
        chk("c4_fs", 32'(fs_o), 0);
        chk("c4_req", 32'(req_o), 0);
        tick();
        chk("rdy011_req_a", 32'(req_o), 0);
        tick();
        chk("rdy011_req_b", 32'(req_o), 0);
        rdy = 3'b111;
        tick();
        chk("rdy111_req", 32'(req_o), 1);

        lack = 1'b1; tick(); lack = 1'b0;
        chk("ack1_line", 32'(line_o), 1);
        chk("ack1_req", 32'(req_o), 0);
        repeat (4) tick();
        chk("ack1_hold", 32'(req_o), 0);
        tick();
        chk("req2", 32'(req_o), 1);

        lack = 1'b1; tick(); lack = 1'b0;
        chk("ack2_line", 32'(line_o), 2);
        chk("ack2_tg", 32'(tg_o), 0);
        lrun = 3'b111;
        tick();
        chk("tg_on", 32'(tg_o), 1);
        repeat (3) tick();
        chk("ack2_hold", 32'(req_o), 0);
        tick();
        chk("req3", 32'(req_o), 1);

        lack = 1'b1; tick(); lack = 1'b0;
        chk("ack3_line", 32'(line_o), 3);
        repeat (5) tick();
        chk("req4", 32'(req_o), 1);
        lack = 1'b1; tick(); lack = 1'b0;
        chk("ack4_line", 32'(line_o), 4);
        repeat (8) tick();
        chk("sat_req", 32'(req_o), 0);
        chk("sat_line", 32'(line_o), 4);

        // full frame at vsync: no underflow
        vs = 1'b1;
        tick();
        chk("vs1_fs", 32'(fs_o), 1);
        chk("vs1_ufl", 32'(ufl_o), 0);
        chk("vs1_tg", 32'(tg_o), 1);
        vs = 1'b0;
        vlines = 12'd8;
        tick();
        chk("fill2_fs", 32'(fs_o), 0);
        chk("fill2_tg", 32'(tg_o), 1);
        tick();
        chk("fill2_req", 32'(req_o), 1);
        for (int i = 0; i < 5; i++) begin
            lack = 1'b1; tick(); lack = 1'b0;
            if (i < 4) repeat (5) tick();
        end
        chk("ufl_line5", 32'(line_o), 5);
        vs = 1'b1;
        tick();
        chk("ufl_set", 32'(ufl_o), 1);
        chk("ufl_fs", 32'(fs_o), 1);
        chk("ufl_line0", 32'(line_o), 0);
        chk("ufl_tg", 32'(tg_o), 1);
        vs = 1'b0;
        tick();
        tick();
        chk("run3_req", 32'(req_o), 1);

        // enable dropped with request outstanding
        en = 1'b0;
        tick();
        chk("dis_run", 32'(run_o), 0);
        chk("dis_req", 32'(req_o), 0);
        chk("dis_tg", 32'(tg_o), 0);
        chk("dis_ufl_held", 32'(ufl_o), 1);
        lack = 1'b1; tick(); lack = 1'b0;
        chk("idle_ufl_clr", 32'(ufl_o), 0);
        chk("late_ack_line", 32'(line_o), 0);
        chk("late_ack_req", 32'(req_o), 0);

        // source timeout
        vlines = 12'd2;
        lrun = 3'b000;
        en = 1'b1;
        repeat (5) tick();
        chk("to_req", 32'(req_o), 1);
        repeat (14) tick();
        chk("to_pre_err", 32'(err_o), 0);
        chk("to_pre_run", 32'(run_o), 1);
        tick();
        chk("to_err", 32'(err_o), 1);
        chk("to_run", 32'(run_o), 0);
        chk("to_tg", 32'(tg_o), 0);
        chk("to_reqoff", 32'(req_o), 0);
        en = 1'b0;
        tick();
        chk("to_err_held", 32'(err_o), 1);
        tick();
        chk("to_err_clr", 32'(err_o), 0);

        // zero-line frame and test pattern
        vlines = 12'd0;
        lrun = 3'b111;
        en = 1'b1;
        repeat (5) tick();
        chk("z_tg", 32'(tg_o), 1);
        tp = 1'b1;
        repeat (6) tick();
        chk("z_req", 32'(req_o), 0);
        chk("z_line", 32'(line_o), 0);
        chk("tp_mid", 32'(tp_o), 0);
        vs = 1'b1;
        tick();
        chk("z_fs", 32'(fs_o), 1);
        chk("z_ufl", 32'(ufl_o), 0);
        chk("tp_fs", 32'(tp_o), 32'(tp_exp));
        vs = 1'b0;

        // asynchronous reset mid-frame
        rst = 1'b1;
        #1;
        chk("arst_run", 32'(run_o), 0);
        chk("arst_tg", 32'(tg_o), 0);
        chk("arst_tp", 32'(tp_o), 0);
        tick();
        rst = 1'b0;
        en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
